// File: rtl/div_seq_ctrl.sv
// Sequencer and A/Q/M register stage for a 4-bit restoring shift-subtract divider.
// Latency 5 edges from accepted start to done; start is ignored while busy (no queuing).
module div_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             clr_add,
    output logic             add_en,
    input  logic [WIDTH-1:0] sum_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [1:0]       r_cnt;
    logic             r_dbz;

    logic [WIDTH:0]   w_s;
    logic             w_ge;

    // Shifted partial remainder; S[WIDTH] stays 0 because A < 2^(WIDTH-1) before each shift.
    assign w_s  = {r_a, r_q[WIDTH-1]};
    assign w_ge = (w_s >= {1'b0, r_m});

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        clr_add     = 1'b1;
        add_a       = '0;
        add_b       = '0;
        add_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = ITER;
            end
            ITER: begin
                busy    = 1'b1;
                clr_add = 1'b0;
                add_a   = w_s[WIDTH-1:0];
                add_b   = r_m;
                if (r_cnt == 2'd3) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= '0;
                        r_q   <= dividend;
                        r_m   <= divisor;
                        r_cnt <= '0;
                        r_dbz <= (divisor == '0);
                    end
                end
                ITER: begin
                    // Restore is implicit: on ge=0 the unsubtracted shift value is kept.
                    r_a   <= w_ge ? sum_i : w_s[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_a;
    assign div_by_zero = r_dbz;

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencer and register stage for the 4-bit unsigned shift-subtract divider. It accepts a dividend/divisor pair on a start pulse and holds the A (partial remainder), Q (dividend/quotient) and M (divisor) registers. Over four iterations it drives the shared combinational add/subtract unit through `add_a`/`add_b`/`clr_add`/`add_en`, consumes its 4-bit result on `sum_i`, and presents quotient and remainder with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 4, operand width; only 4 is supported, matching the add/subtract unit
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `dividend`  in  4  unsigned dividend, captured when start is accepted
- `divisor`  in  4  unsigned divisor, captured when start is accepted
- `busy`  out  1  high while in ITER
- `done`  out  1  one-cycle pulse in DONE
- `quotient`  out  4  registered result Q
- `remainder`  out  4  registered result A
- `div_by_zero`  out  1  set when the captured divisor is 0; valid with done
- `add_a`  out  4  minuend to the add/subtract unit
- `add_b`  out  4  subtrahend to the add/subtract unit
- `clr_add`  out  1  forces the add/subtract unit output to 0
- `add_en`  out  1  1 = add, 0 = subtract; this block always drives 0
- `sum_i`  in  4  result from the add/subtract unit (`add_a - add_b` mod 16)

## Operation
- States: IDLE, ITER, DONE. Iteration counter `cnt` is 2 bits.
- In IDLE, `start` = 1 at an edge:
  - A ← 0, Q ← dividend, M ← divisor, cnt ← 0
  - `div_by_zero` ← (divisor == 0)
  - state → ITER
- In IDLE, `start` = 0: hold all registers.
- In ITER, each cycle:
  - Form S = {A, Q[3]}, 5 bits.
  - Drive `add_a` = S[3:0], `add_b` = M, `clr_add` = 0, `add_en` = 0.
  - ge = (S ≥ {1'b0, M}), a 5-bit unsigned compare.
  - At the edge: A ← ge ? `sum_i` : S[3:0]; Q ← {Q[2:0], ge}; cnt ← cnt + 1.
  - When cnt == 3 at the edge, state → DONE.
- Width rule: with 4-bit operands, A < 8 before every shift, so S[4] is always 0. The modulo-16 subtract is therefore exact when ge = 1.
- The restore step is implicit: when ge = 0, S[3:0] is committed and `sum_i` is ignored.
- DONE: `done` = 1 for exactly one cycle; state → IDLE unconditionally.
- `quotient` = Q and `remainder` = A at all times. They are valid from DONE and held until the next accepted start.
- `start` is ignored in ITER and DONE; no queuing.
- Divisor 0: the algorithm runs unchanged. Every iteration has ge = 1, giving Q = 4'hF and A = dividend. `div_by_zero` = 1.
- Outside ITER: `clr_add` = 1, `add_a` = 0, `add_b` = 0, `add_en` = 0.

## Timing
- Reset values: state IDLE, A = Q = M = 0, cnt = 0.
  - Outputs: `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0.
  - Adder controls: `clr_add` = 1, `add_a` = `add_b` = 0, `add_en` = 0.
- Latency: start accepted at edge k. ITER is active in cycles k+1..k+4. `done` is high in the cycle after edge k+4, i.e. five edges after acceptance.
- Throughput: one division per 6 cycles, because DONE returns to IDLE before a new start is sampled.
- `busy` rises the cycle after acceptance and falls when DONE is entered.
- `sum_i` is consumed in the same cycle it is driven (combinational loop through the add/subtract unit). There is no register between `add_a`/`add_b` and `sum_i`.
- `rst` mid-operation: at the next edge, return to IDLE and the reset values. No `done` is issued for the aborted division.
- `rst` and `start` high together: reset wins and start is dropped.

## Test plan
- Reset, then `start` with 13/3 → `busy` for 4 cycles, `done` at edge k+5, `quotient` = 4, `remainder` = 1, `div_by_zero` = 0.
- 15/1 → `quotient` = 15, `remainder` = 0. Then 7/9 → `quotient` = 0, `remainder` = 7, and `sum_i` is never committed.
- 9/0 → `quotient` = 4'hF, `remainder` = 9, `div_by_zero` = 1, same 5-edge latency.
- 12/5, with `start` pulsed again in ITER cycles 2 and 3 using 1/1 → results still `quotient` = 2, `remainder` = 2; exactly one `done`.
- Assert `rst` during the 2nd ITER cycle of 14/4 → next cycle `busy` = 0 and all outputs at reset values, no `done`. Then 14/4 → `quotient` = 3, `remainder` = 2.
- Every cycle, check: `clr_add` = !`busy`, `add_en` = 0, and in ITER `add_b` = captured divisor.
